// File: rtl/board_ctrl_pkg.sv
// Shared constants and state encoding for the 8x8 paint board controller.
package board_ctrl_pkg;

    localparam int BOARD_W   = 8;
    localparam int BOARD_H   = 8;
    localparam int CELL_BITS = 12;
    localparam int CELLS     = BOARD_W * BOARD_H;

    localparam logic [CELL_BITS-1:0] COLOR_BLACK = 12'h000;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/board_ctrl_btn_edge.sv
// One-bit button register with a single-cycle rising-edge pulse.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic btn_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn;
        end
    end

    assign pulse = btn & ~btn_q;

endmodule

// File: rtl/board_ctrl.sv
// 8x8 paint board: cursor movement, painting, board clear and blinking cursor.
module board_ctrl
    import board_ctrl_pkg::*;
#(
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic                       btn_left,
    input  logic                       btn_right,
    input  logic                       btn_paint,
    input  logic                       btn_clear,
    input  logic [CELL_BITS-1:0]       sw_color,
    output logic [CELLS*CELL_BITS-1:0] board_data,
    output logic [2:0]                 cursor_row,
    output logic [2:0]                 cursor_col,
    output logic                       busy
);

    localparam int CW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;

    logic ev_up, ev_down, ev_left, ev_right, ev_paint, ev_clear;

    btn_edge u_up    (.clk(clk), .rst(rst), .btn(btn_up),    .pulse(ev_up));
    btn_edge u_down  (.clk(clk), .rst(rst), .btn(btn_down),  .pulse(ev_down));
    btn_edge u_left  (.clk(clk), .rst(rst), .btn(btn_left),  .pulse(ev_left));
    btn_edge u_right (.clk(clk), .rst(rst), .btn(btn_right), .pulse(ev_right));
    btn_edge u_paint (.clk(clk), .rst(rst), .btn(btn_paint), .pulse(ev_paint));
    btn_edge u_clear (.clk(clk), .rst(rst), .btn(btn_clear), .pulse(ev_clear));

    state_t               state, state_next;
    logic [CELL_BITS-1:0] cells [CELLS];
    logic [5:0]           clr_idx;
    logic [5:0]           cur_idx;
    logic [2:0]           row_next, col_next;
    logic [CW-1:0]        blink_cnt;
    logic                 blink_ph;

    assign cur_idx = {cursor_row, cursor_col};
    assign busy    = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (ev_clear) state_next = CLEAR;
            CLEAR: if (clr_idx == 6'(CELLS - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Opposing presses in one cycle cancel; each axis moves independently.
    always_comb begin
        row_next = cursor_row;
        col_next = cursor_col;
        unique case ({ev_up, ev_down})
            2'b10:   row_next = cursor_row - 3'd1;
            2'b01:   row_next = cursor_row + 3'd1;
            default: row_next = cursor_row;
        endcase
        unique case ({ev_left, ev_right})
            2'b10:   col_next = cursor_col - 3'd1;
            2'b01:   col_next = cursor_col + 3'd1;
            default: col_next = cursor_col;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CELLS; i++) cells[i] <= COLOR_BLACK;
            cursor_row <= 3'd0;
            cursor_col <= 3'd0;
            clr_idx    <= 6'd0;
        end else if (state == CLEAR) begin
            cells[clr_idx] <= COLOR_BLACK;
            clr_idx        <= clr_idx + 6'd1;
        end else if (ev_clear) begin
            clr_idx <= 6'd0;
        end else if (ev_paint) begin
            cells[cur_idx] <= sw_color;
        end else begin
            cursor_row <= row_next;
            cursor_col <= col_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == CW'(BLINK_CYCLES - 1)) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + CW'(1);
        end
    end

    // Cursor cell is shown inverted on the lit blink phase, never while clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            board_data <= '0;
        end else begin
            for (int i = 0; i < CELLS; i++) begin
                if (6'(i) == cur_idx && blink_ph && state == IDLE)
                    board_data[CELL_BITS*i +: CELL_BITS] <= ~cells[i];
                else
                    board_data[CELL_BITS*i +: CELL_BITS] <= cells[i];
            end
        end
    end

endmodule

// File: tb/tb_board_ctrl.sv
// Directed plus random stimulus against a cycle-level board model.
module tb_board_ctrl;

    localparam int B = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         btn_up, btn_down, btn_left, btn_right, btn_paint, btn_clear;
    logic [11:0]  sw_color;
    logic [767:0] board_data;
    logic [2:0]   cursor_row, cursor_col;
    logic         busy;

    board_ctrl #(.BLINK_CYCLES(B)) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right),
        .btn_paint(btn_paint), .btn_clear(btn_clear),
        .sw_color(sw_color), .board_data(board_data),
        .cursor_row(cursor_row), .cursor_col(cursor_col),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Behavioural board: plain arrays and integer arithmetic.
    int           m_cells [64];
    int           m_row, m_col, m_cidx, m_k;
    bit           m_busy;
    bit   [5:0]   m_prev;
    logic [767:0] m_disp;

    localparam logic [5:0] UP = 6'd1, DN = 6'd2, LF = 6'd4,
                           RT = 6'd8, PT = 6'd16, CL = 6'd32;

    task automatic check(string tag, logic [767:0] obs, logic [767:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(logic [5:0] b, logic r);
        bit [5:0] ev;
        int       phase;
        btn_up = b[0]; btn_down = b[1]; btn_left = b[2];
        btn_right = b[3]; btn_paint = b[4]; btn_clear = b[5];
        rst = r;
        @(posedge clk);
        if (r) begin
            foreach (m_cells[i]) m_cells[i] = 0;
            m_row = 0; m_col = 0; m_busy = 0; m_cidx = 0;
            m_k = 0; m_prev = '0; m_disp = '0;
        end else begin
            phase = (m_k / B) % 2;
            for (int i = 0; i < 64; i++) begin
                if (i == m_row * 8 + m_col && phase == 1 && !m_busy)
                    m_disp[12*i +: 12] = ~12'(m_cells[i]);
                else
                    m_disp[12*i +: 12] = 12'(m_cells[i]);
            end
            ev = b & ~m_prev;
            m_prev = b;
            if (m_busy) begin
                m_cells[m_cidx] = 0;
                if (m_cidx == 63) m_busy = 0;
                m_cidx++;
            end else if (ev[5]) begin
                m_busy = 1;
                m_cidx = 0;
            end else if (ev[4]) begin
                m_cells[m_row * 8 + m_col] = int'(sw_color);
            end else begin
                m_row = (m_row + 8 + int'(ev[1]) - int'(ev[0])) % 8;
                m_col = (m_col + 8 + int'(ev[3]) - int'(ev[2])) % 8;
            end
            m_k++;
        end
        #1;
        check("board_data", board_data, m_disp);
        check("cursor_row", 768'(cursor_row), 768'(m_row));
        check("cursor_col", 768'(cursor_col), 768'(m_col));
        check("busy", 768'(busy), 768'(m_busy));
    endtask

    task automatic pulse(logic [5:0] b);
        step(b, 1'b0);
        step(6'd0, 1'b0);
    endtask

    int busy_cnt;
    int exp_cell;

    initial begin
        sw_color = 12'h000;
        step(6'd0, 1'b1);
        check("reset_zero", board_data, '0);

        // Held right moves once, then seven pulses wrap the column.
        step(RT, 1'b0); step(RT, 1'b0); step(RT, 1'b0);
        check("hold_one_move", 768'(cursor_col), 768'(1));
        step(6'd0, 1'b0);
        for (int i = 0; i < 7; i++) pulse(RT);
        check("col_wrap", 768'(cursor_col), 768'(0));

        pulse(UP);
        check("row_wrap_up", 768'(cursor_row), 768'(7));
        pulse(UP | DN);
        check("up_down_cancel", 768'(cursor_row), 768'(7));

        for (int i = 0; i < 3; i++) pulse(DN);
        for (int i = 0; i < 5; i++) pulse(RT);
        sw_color = 12'hF0A;
        step(PT, 1'b0);
        step(6'd0, 1'b0);
        exp_cell = ((m_k - 1) / B) % 2 == 1 ? 'h0F5 : 'hF0A;
        check("cell21_view", 768'(board_data[263:252]), 768'(exp_cell));

        sw_color = 12'h123; pulse(RT); pulse(PT);
        sw_color = 12'hABC; pulse(DN); pulse(PT);
        step(CL, 1'b0);
        busy_cnt = 1;
        for (int i = 0; i < 80 && busy; i++) begin
            sw_color = 12'($urandom);
            step(6'($urandom_range(0, 31)), 1'b0);
            if (busy) busy_cnt++;
        end
        check("busy_len", 768'(busy_cnt), 768'(64));
        for (int i = 0; i < 3; i++) step(6'd0, 1'b0);

        pulse(CL);
        for (int i = 0; i < 29; i++) step(6'd0, 1'b0);
        step(6'd0, 1'b1);
        check("rst_mid_clear", 768'(busy), 768'(0));

        sw_color = 12'h5A5;
        step(PT | RT, 1'b0);
        check("paint_wins_col", 768'(cursor_col), 768'(0));
        step(6'd0, 1'b0);
        exp_cell = ((m_k - 1) / B) % 2 == 1 ? 'hA5A : 'h5A5;
        check("paint_wins_cell", 768'(board_data[11:0]), 768'(exp_cell));

        for (int i = 0; i < 600; i++) begin
            sw_color = 12'($urandom);
            step(6'($urandom) & 6'($urandom), ($urandom_range(0, 199) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/board_ctrl.md
BOARD_CTRL -- requirements
Module: board_ctrl

Interface
REQ-001 BLINK_CYCLES, 25_000_000, clk cycles per cursor blink half-period (min 2).
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 btn_up / btn_down / btn_left / btn_right  input  1 each  debounced, clk-synchronous move requests, level.
REQ-005 btn_paint  input  1  debounced level; rising edge writes sw_color into cursor cell.
REQ-006 btn_clear  input  1  debounced level; rising edge starts whole-board clear.
REQ-007 sw_color  input  12  paint colour {R[3:0],G[3:0],B[3:0]}.
REQ-008 board_data  output  768  64 cells x 12 bit; cell i = row*8+col at bits [12*i+11 : 12*i]; feeds the display data path.
REQ-009 cursor_row, cursor_col  output  3 each  current cursor position.
REQ-010 busy  output  1  high while clear is in progress.

Function
REQ-011 Each button SHALL be registered once; an event SHALL be btn & ~btn_q; level holds SHALL produce exactly one event.
REQ-012 FSM states SHALL be IDLE and CLEAR only.
REQ-013 In IDLE, on the edge where an event is detected, its effect SHALL be visible in registers after that same edge.
REQ-014 Priority in IDLE SHALL be clear > paint > moves; same-cycle paint SHALL write the pre-move cursor cell, and moves in that cycle SHALL be discarded.
REQ-015 up decrements and down increments row; left decrements and right increments col; all SHALL wrap modulo 8 (row 0 up -> 7, col 7 right -> 0).
REQ-016 Simultaneous up+down SHALL leave row unchanged; simultaneous left+right SHALL leave col unchanged; row and col moves in the same cycle SHALL both apply.
REQ-017 Clear event: FSM -> CLEAR, busy=1, a 6-bit index SHALL write 12'h000 to cells 0..63, one per cycle; after the cell-63 write, FSM -> IDLE, busy=0 (busy high exactly 64 cycles).
REQ-018 In CLEAR, all button events SHALL be ignored (not queued); cursor SHALL NOT move; btn_q SHALL keep tracking inputs.
REQ-019 A blink counter SHALL count 0..BLINK_CYCLES-1 and toggle blink phase on wrap; it SHALL run in all states.
REQ-020 board_data SHALL be registered: cell i = stored colour, except the cursor cell shows bitwise ~colour while blink phase = 1 and FSM = IDLE; latency stored-cell/cursor change -> board_data = 1 cycle.
REQ-021 No overlay SHALL be applied during CLEAR.

Reset
REQ-022 On rst=1 at a clock edge: all cells = 12'h000, cursor = (0,0), FSM = IDLE, busy = 0, blink counter = 0, phase = 0, btn_q = 0, board_data = 0.
REQ-023 rst during CLEAR SHALL abort the clear and apply REQ-022 (reset overrides every event).
REQ-024 Buttons held high through reset release SHALL produce one event on the first post-reset edge (btn_q cleared).

Structure
REQ-025 Shared package: BOARD_W=8, BOARD_H=8, CELL_BITS=12, CELLS=64, FSM state encoding, COLOR_BLACK=12'h000.
REQ-026 One sub-module, btn_edge (register + rising-edge pulse, 1 bit), instantiated per button; cell storage stays as a flat 64x12 register array in board_ctrl.

Verification
REQ-027 Reset, btn_right held 3 cycles -> cursor_col 0->1 only; release, pulse 7 more -> col wraps to 0.
REQ-028 Cursor (0,0), btn_up pulse -> row 7; btn_up+btn_down same cycle -> row unchanged.
REQ-029 Cursor (2,5), sw_color=12'hF0A, paint pulse -> cell 21 = 12'hF0A; board_data[263:252] = 12'hF0A or 12'h0F5 by phase, one cycle later.
REQ-030 Paint 3 cells, clear pulse -> busy high exactly 64 cycles; moves/paints during busy ignored; afterwards board_data = 0 apart from cursor overlay.
REQ-031 BLINK_CYCLES=4: cursor cell toggles every 4 cycles; rst asserted at clear index 30 -> all REQ-022 values next cycle.
REQ-032 paint+right same cycle at (0,0) -> cell 0 written, cursor stays (0,0).
